// File: rtl/pal_cfg_loader.sv
// PAL config loader: byte handshake in, MSB-first serial stream out.
// Optional CRC-8 trailer check enabled by defining CFG_CRC_EN.
module pal_cfg_loader #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       START,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       CFG,
  output logic       CFG_SHIFT,
  output logic       BUSY,
  output logic       DONE,
  output logic       CRC_ERR
);

  localparam int SR_LEN = 2*N*P + P*M;
  localparam int CW     = $clog2(SR_LEN+1);

`ifdef CFG_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_CRC
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_DONE
  } state_t;
`endif

  state_t        state, nxt;
  logic [7:0]    hold;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic          restart;
  logic          take;
  logic          last_bit;
  logic          byte_end;

  assign restart  = START &
                    ((state == S_IDLE) |
                     (state == S_DONE));
  assign take     = DATA_VALID &
                    (state == S_LOAD);
  assign last_bit = bit_cnt == CW'(SR_LEN-1);
  assign byte_end = bit_idx == 3'd7;

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    DATA_READY = 1'b0;
    CFG_SHIFT  = 1'b0;
    CFG        = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START) nxt = S_LOAD;
      end
      S_LOAD: begin
        DATA_READY = 1'b1;
        BUSY       = 1'b1;
        if (DATA_VALID) nxt = S_SHIFT;
      end
      S_SHIFT: begin
        BUSY      = 1'b1;
        CFG_SHIFT = 1'b1;
        CFG       = hold[7];
`ifdef CFG_CRC_EN
        if (last_bit)      nxt = S_CRC;
`else
        if (last_bit)      nxt = S_DONE;
`endif
        else if (byte_end) nxt = S_LOAD;
      end
`ifdef CFG_CRC_EN
      S_CRC: begin
        DATA_READY = 1'b1;
        BUSY       = 1'b1;
        if (DATA_VALID) nxt = S_DONE;
      end
`endif
      S_DONE: begin
        DONE = 1'b1;
        if (START) nxt = S_LOAD;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      hold    <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if (restart) bit_cnt <= '0;
      if (take) begin
        hold    <= DATA_IN;
        bit_idx <= '0;
      end
      if (CFG_SHIFT) begin
        hold    <= {hold[6:0], 1'b0};
        bit_idx <= bit_idx + 3'd1;
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

`ifdef CFG_CRC_EN
  logic [7:0] crc;
  logic       crc_err;
  logic       crc_take;

  assign crc_take = DATA_VALID &
                    (state == S_CRC);

  // Running CRC-8 (poly 0x07) folded in a byte at a time
  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07)
               : {r[6:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      crc     <= '0;
      crc_err <= 1'b0;
    end else if (restart) begin
      crc     <= '0;
      crc_err <= 1'b0;
    end else begin
      if (take)     crc     <= crc8(crc, DATA_IN);
      if (crc_take) crc_err <= DATA_IN != crc;
    end
  end

  assign CRC_ERR = crc_err;
`else
  assign CRC_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: random payloads, queue scoreboard on CFG,
// plus a 27-bit instance for the partial last byte.
module tb_pal_cfg_loader;

  localparam int SR = 192;
  localparam int NB = 24;
`ifdef CFG_CRC_EN
  localparam int LAT = 217;
`else
  localparam int LAT = 216;
`endif

  logic       CLK = 0;
  logic       RES_N = 0;
  logic       START = 0;
  logic [7:0] DATA_IN = 0;
  logic       DATA_VALID = 0;
  logic       DATA_READY, CFG, CFG_SHIFT;
  logic       BUSY, DONE, CRC_ERR;

  logic       s2_start = 0;
  logic [7:0] s2_data = 0;
  logic       s2_valid = 0;
  logic       s2_ready, s2_cfg, s2_shift;
  logic       s2_busy, s2_done, s2_crc_err;

  pal_cfg_loader u_dut (
    .CLK(CLK), .RES_N(RES_N), .START(START),
    .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .CFG(CFG),
    .CFG_SHIFT(CFG_SHIFT), .BUSY(BUSY),
    .DONE(DONE), .CRC_ERR(CRC_ERR)
  );

  pal_cfg_loader #(.N(3), .M(3), .P(3)) u_dut27 (
    .CLK(CLK), .RES_N(RES_N), .START(s2_start),
    .DATA_IN(s2_data), .DATA_VALID(s2_valid),
    .DATA_READY(s2_ready), .CFG(s2_cfg),
    .CFG_SHIFT(s2_shift), .BUSY(s2_busy),
    .DONE(s2_done), .CRC_ERR(s2_crc_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int acc_cnt = 0;
  int inv_err = 0;
  int done_cyc = -1;
  bit sb_en = 0;
  bit exp_q[$];
  bit got2[$];
  logic [7:0] payload[$];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  // Reference CRC-8: polynomial division over the bit stream
  function automatic logic [7:0] crc_ref(
    input logic [7:0] msg[$]);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    foreach (msg[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ msg[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    return c;
  endfunction

  always @(negedge CLK) begin
    if (RES_N) begin
      if (!CFG_SHIFT && CFG !== 1'b0) inv_err++;
      if (CFG_SHIFT && DATA_READY) inv_err++;
      if (s2_shift && s2_ready) inv_err++;
      if (DATA_VALID && DATA_READY) acc_cnt++;
      if (DONE && done_cyc < 0) done_cyc = cyc;
      if (s2_shift) got2.push_back(s2_cfg);
      if (sb_en && CFG_SHIFT) begin
        pulses++;
        if (exp_q.size() == 0)
          chk("extra_shift", 1, 0);
        else
          chk("cfg_bit", {31'd0, CFG},
              {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_load(input int vprob,
                         input int start_at,
                         input bit bad,
                         input bit chk_lat);
    int idx, guard, t0, nxf;
    logic rdy;
    bit sdone;
    logic [7:0] crcb;
    exp_q.delete();
    foreach (payload[i])
      for (int j = 7; j >= 0; j--)
        if (i*8 + 7 - j < SR)
          exp_q.push_back(payload[i][j]);
    crcb = crc_ref(payload) ^ {7'd0, bad};
    nxf = NB;
`ifdef CFG_CRC_EN
    nxf = NB + 1;
`endif
    pulses = 0; acc_cnt = 0; done_cyc = -1;
    idx = 0; guard = 0; sdone = 0;
    @(posedge CLK); #1;
    START = 1; DATA_VALID = 1; DATA_IN = payload[0];
    @(posedge CLK); #1;
    t0 = cyc; START = 0;
    while (idx < nxf && guard < 3000) begin
      DATA_IN = idx < NB ? payload[idx] : crcb;
      DATA_VALID = (vprob >= 100) ||
                   ($urandom_range(99) < vprob);
      START = !sdone && idx == start_at;
      if (START) sdone = 1;
      @(negedge CLK);
      rdy = DATA_READY;
      if (guard == 0) begin
        chk("start_clears_done", {31'd0, DONE}, 0);
        chk("busy_after_start", {31'd0, BUSY}, 1);
      end
      @(posedge CLK);
      if (DATA_VALID && rdy) idx++;
      #1 guard++;
    end
    START = 0; DATA_VALID = 0;
    chk("feed_timeout", idx, nxf);
    for (int k = 0; k < 50 && DONE !== 1'b1; k++)
      @(negedge CLK);
    @(negedge CLK);
    chk("done_level", {31'd0, DONE}, 1);
    if (chk_lat) chk("done_latency", done_cyc - t0, LAT);
    chk("shift_pulses", pulses, SR);
    chk("stream_left", exp_q.size(), 0);
    chk("accepts", acc_cnt, nxf);
    chk("busy_at_done", {31'd0, BUSY}, 0);
`ifdef CFG_CRC_EN
    chk("crc_err", {31'd0, CRC_ERR}, {31'd0, bad});
`else
    chk("crc_err", {31'd0, CRC_ERR}, 0);
`endif
  endtask

  task automatic rand_payload();
    payload.delete();
    for (int i = 0; i < NB; i++)
      payload.push_back(8'($urandom));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b2[$];
    logic [7:0] c2;
    int idx, n2;
    logic rdy;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs",
        {26'd0, DATA_READY, CFG, CFG_SHIFT,
         BUSY, DONE, CRC_ERR}, 0);
    RES_N = 1;
    sb_en = 1;

    payload.delete();
    for (int i = 0; i < NB; i++)
      payload.push_back(8'(i));
    do_load(100, -1, 0, 1);

    rand_payload();
    do_load(50, 10, 0, 0);

    // Reset in the middle of shifting the first byte
    sb_en = 0;
    @(posedge CLK); #1;
    START = 1; DATA_VALID = 1; DATA_IN = 8'hA5;
    @(posedge CLK); #1 START = 0;
    for (int k = 0; k < 20 && CFG_SHIFT !== 1'b1; k++)
      @(negedge CLK);
    @(negedge CLK);
    chk("shift_before_reset", {31'd0, CFG_SHIFT}, 1);
    RES_N = 0;
    #1;
    chk("async_reset_outs",
        {26'd0, DATA_READY, CFG, CFG_SHIFT,
         BUSY, DONE, CRC_ERR}, 0);
    DATA_VALID = 0;
    @(posedge CLK); #1 RES_N = 1;
    sb_en = 1;

    rand_payload();
    do_load(100, -1, 0, 1);

`ifdef CFG_CRC_EN
    rand_payload();
    do_load(70, -1, 1, 0);
    rand_payload();
    do_load(100, -1, 0, 1);
`endif

    // 27-bit chain: 4 bytes, only 3 bits of the last one used
    got2.delete();
    b2 = '{8'($urandom), 8'($urandom),
           8'($urandom), 8'hE0};
    c2 = crc_ref(b2);
    n2 = 4;
`ifdef CFG_CRC_EN
    n2 = 5;
`endif
    @(posedge CLK); #1;
    s2_start = 1; s2_valid = 1; s2_data = b2[0];
    @(posedge CLK); #1 s2_start = 0;
    idx = 0;
    for (int g = 0; g < 200 && idx < n2; g++) begin
      s2_data = idx < 4 ? b2[idx] : c2;
      @(negedge CLK);
      rdy = s2_ready;
      @(posedge CLK);
      if (rdy) idx++;
      #1;
    end
    s2_valid = 0;
    chk("p27_feed", idx, n2);
    for (int k = 0; k < 50 && s2_done !== 1'b1; k++)
      @(negedge CLK);
    chk("p27_done", {31'd0, s2_done}, 1);
    chk("p27_crc_err", {31'd0, s2_crc_err}, 0);
    chk("p27_bits", got2.size(), 27);
    for (int i = 0; i < 27 && i < got2.size(); i++)
      chk("p27_bit", {31'd0, got2[i]},
          {31'd0, b2[i/8][7 - i%8]});

    chk("invariants", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
